event_stimulus_player: RTL and testbench
========================================

Name: event_stimulus_player

Overview:
- Synthesizable, parametrised replacement for hand-written timed stimulus sequences that drive the generated monitor top entity.
- Stores a table of timestamped input events, then replays each as a one-cycle `new_input` pulse with data on NUM_INPUTS channels at the scheduled cycle.
- Sits between a loader (host or ROM sequencer) and the monitor's `input_k` / `new_input_k` ports.
- Supports simultaneous multi-channel events and reports late events.

Parameters:
- NUM_INPUTS, 1, number of monitor input streams.
- DATA_W, 64, width of each input value (signed, two's complement).
- DEPTH, 16, number of event slots; power of two, >=2.
- TS_W, 32, timestamp / cycle-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  global enable; low freezes time and emission.
- ld_valid  in  1  load handshake valid.
- ld_ready  out  1  load handshake ready.
- ld_ts  in  TS_W  absolute event time, in cycles after start.
- ld_mask  in  NUM_INPUTS  channels carrying a new value in this event.
- ld_data  in  NUM_INPUTS*DATA_W  per-channel values; channel k at bits [k*DATA_W +: DATA_W].
- start  in  1  begin replay (level-sampled in IDLE).
- clear  in  1  empty the table (IDLE only).
- input_data  out  NUM_INPUTS*DATA_W  values to monitor.
- new_input  out  NUM_INPUTS  one-cycle valid per channel.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- time_now  out  TS_W  replay cycle counter.
- evt_count  out  $clog2(DEPTH)+1  number of loaded events.
- late_cnt  out  8  saturating count of late events.

Behaviour:
- Reset (rst==0 at edge):
  - State IDLE.
  - Table emptied; evt_count=0.
  - new_input=0, input_data=0, time_now=0, late_cnt=0, busy=0, done=0.
  - Reset mid-RUN aborts replay immediately; the table is lost.
- States: IDLE, RUN, DONE.
- IDLE:
  - ld_ready = (evt_count<DEPTH).
  - An event is written at slot evt_count when ld_valid&&ld_ready; evt_count increments.
  - clear has priority over load; it sets evt_count=0.
  - start==1:
    - If evt_count==0, go to DONE.
    - Otherwise go to RUN with rd_ptr=0, time_now=0, late_cnt=0.
  - start has priority over a simultaneous load; that load is not accepted because ld_ready is forced 0 when start==1.
- RUN:
  - ld_ready=0; clear is ignored; busy=1.
  - Each cycle with en=1, time_now increments, wrapping at 2^TS_W.
  - Emission rule: at an edge where en=1 and the event at rd_ptr has ts<=time_now:
    - register new_input=ld_mask of that event;
    - register input_data with the masked channel values; unmasked channels are 0;
    - increment rd_ptr.
  - Pulse width:
    - Outputs last exactly one cycle.
    - Next cycle they return to 0 unless the following event also qualifies.
    - At most one event is emitted per cycle; events with equal ts go out on consecutive cycles.
  - Late events:
    - An event is late if its ts < time_now at emission, e.g. non-monotonic table or equal-ts backlog.
    - Each late event increments late_cnt, saturating at 255.
    - An event whose ts==time_now is on time.
  - Timing: an event with ts=T loaded in a table starting at time 0 with no backlog shows new_input high in the cycle where time_now==T+1. The outputs are registered at the same edge the counter advances.
  - en=0: time_now holds, no emission, new_input forced 0, input_data holds 0.
  - After emitting the event at index evt_count-1, go to DONE on the next edge.
- DONE:
  - done=1; new_input=0; time_now holds.
  - start is ignored.
  - clear returns the block to IDLE with an empty table.
  - ld_ready=0.
- An all-zero ld_mask is legal: it consumes a slot and emits nothing, but still counts for lateness.

Optional Feature:
- Macro `EVENT_PLAYER_LOOP_EN`.
- When defined, adds input port `loop` (1 bit).
  - If loop==1 when the last event is emitted, the block stays in RUN with rd_ptr=0 and time_now=0 on the next edge.
  - late_cnt is retained across loops.
  - If loop==0, the block goes to DONE as normal.
- When undefined:
  - The port is absent.
  - Behaviour is as above: DONE is always reached after the last event.

Test Plan:
- Reset/empty: hold rst=0 3 cycles, then start=1 with no loads -> all outputs 0 during reset; done=1 one edge after start; new_input never asserted.
- Single channel: NUM_INPUTS=1, load (50,1,1),(100,1,2),(150,1,3), start -> new_input pulses exactly 1 cycle each at time_now=51/101/151, input_data=1/2/3, 0 otherwise; late_cnt=0; done after last.
- Multi-channel: NUM_INPUTS=4, event ts=10, mask=4'b0101, data ch0=-7, ch2=9 -> new_input=4'b0101 for one cycle; ch0=-7, ch2=9, ch1=ch3=0.
- Equal timestamps and late: load ts 20,20,5 -> pulses at time_now 21,22,23; late_cnt=2.
- Full/handshake: DEPTH=4, offer 5 loads -> ld_ready drops after the 4th; evt_count=4; 5th not stored. en=0 for 10 cycles mid-RUN -> time_now frozen, no pulses, emission times shifted by 10.
- Reset mid-run: rst=0 at time_now=30 -> next cycle IDLE, evt_count=0, new_input=0. With EVENT_PLAYER_LOOP_EN and loop=1, 2-event table -> sequence repeats with time_now restarting at 0.

Source files
------------

// File: rtl/event_stimulus_player_if.sv
// Load bus between an event loader (host or ROM sequencer) and event_stimulus_player.
// The loader drives master; the player takes slave and returns ld_ready.
interface event_stimulus_player_if #(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_W     = 64,
    parameter int TS_W       = 32
);
    logic                         ld_valid;
    logic                         ld_ready;
    logic [TS_W-1:0]              ld_ts;
    logic [NUM_INPUTS-1:0]        ld_mask;
    logic [NUM_INPUTS*DATA_W-1:0] ld_data;

    modport master (
        output ld_valid, ld_ts, ld_mask, ld_data,
        input  ld_ready
    );

    modport slave (
        input  ld_valid, ld_ts, ld_mask, ld_data,
        output ld_ready
    );
endinterface

// File: rtl/event_stimulus_player.sv
// Replays a loaded table of timestamped events as one-cycle new_input pulses for the monitor.
// Optional EVENT_PLAYER_LOOP_EN adds a loop input that restarts replay after the last event.
module event_stimulus_player #(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
`ifdef EVENT_PLAYER_LOOP_EN
    input  logic                         loop,
`endif
    input  logic                         start,
    input  logic                         clear,
    event_stimulus_player_if.slave       ld,
    output logic [NUM_INPUTS*DATA_W-1:0] input_data,
    output logic [NUM_INPUTS-1:0]        new_input,
    output logic                         busy,
    output logic                         done,
    output logic [TS_W-1:0]              time_now,
    output logic [$clog2(DEPTH):0]       evt_count,
    output logic [7:0]                   late_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t                       state_q;
    logic [CW-1:0]                evt_count_q;
    logic [CW-1:0]                rd_ptr_q;
    logic [TS_W-1:0]              time_now_q;
    logic [7:0]                   late_cnt_q;
    logic [NUM_INPUTS-1:0]        new_input_q;
    logic [NUM_INPUTS*DATA_W-1:0] input_data_q;
    logic                         busy_q;
    logic                         done_q;

    logic [TS_W-1:0]              ts_mem_q   [DEPTH];
    logic [NUM_INPUTS-1:0]        mask_mem_q [DEPTH];
    logic [NUM_INPUTS*DATA_W-1:0] data_mem_q [DEPTH];

    logic [AW-1:0]                rd_idx_s;
    logic [TS_W-1:0]              head_ts_s;
    logic [NUM_INPUTS-1:0]        head_mask_s;
    logic [NUM_INPUTS*DATA_W-1:0] head_data_s;
    logic [NUM_INPUTS*DATA_W-1:0] masked_data_s;
    logic                         pending_s;
    logic                         emit_s;
    logic                         late_s;
    logic                         ld_ready_s;
    logic                         load_s;

    // Head-of-table decode, emission qualification and load handshake.
    always_comb begin
        rd_idx_s      = rd_ptr_q[AW-1:0];
        head_ts_s     = ts_mem_q[rd_idx_s];
        head_mask_s   = mask_mem_q[rd_idx_s];
        head_data_s   = data_mem_q[rd_idx_s];
        pending_s     = (rd_ptr_q < evt_count_q);
        late_s        = (head_ts_s < time_now_q);
        masked_data_s = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (head_mask_s[k]) begin
                masked_data_s[k*DATA_W +: DATA_W] = head_data_s[k*DATA_W +: DATA_W];
            end else begin
                masked_data_s[k*DATA_W +: DATA_W] = '0;
            end
        end
        if ((state_q == S_RUN) && en && pending_s && (head_ts_s <= time_now_q)) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
        // start wins over a simultaneous load, so ready drops while start is high.
        if ((state_q == S_IDLE) && (evt_count_q < DEPTH_C) && !start) begin
            ld_ready_s = 1'b1;
        end else begin
            ld_ready_s = 1'b0;
        end
        load_s = ld_ready_s && ld.ld_valid && !clear;
    end

    // Event table storage; contents are invalidated by clearing evt_count.
    always_ff @(posedge clk) begin
        if (load_s) begin
            ts_mem_q[evt_count_q[AW-1:0]]   <= ld.ld_ts;
            mask_mem_q[evt_count_q[AW-1:0]] <= ld.ld_mask;
            data_mem_q[evt_count_q[AW-1:0]] <= ld.ld_data;
        end
    end

    // Control FSM with registered replay outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            evt_count_q  <= '0;
            rd_ptr_q     <= '0;
            time_now_q   <= '0;
            late_cnt_q   <= 8'd0;
            new_input_q  <= '0;
            input_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            new_input_q  <= '0;
            input_data_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        evt_count_q <= '0;
                    end else if (start) begin
                        if (evt_count_q == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RUN;
                            busy_q     <= 1'b1;
                            rd_ptr_q   <= '0;
                            time_now_q <= '0;
                            late_cnt_q <= 8'd0;
                        end
                    end else if (load_s) begin
                        evt_count_q <= evt_count_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        time_now_q <= time_now_q + 1'b1;
                    end
                    if (emit_s) begin
                        new_input_q  <= head_mask_s;
                        input_data_q <= masked_data_s;
                        rd_ptr_q     <= rd_ptr_q + 1'b1;
                        if (late_s && (late_cnt_q != 8'hFF)) begin
                            late_cnt_q <= late_cnt_q + 8'd1;
                        end
                    end
                    // Table exhausted: the edge after the last emission ends (or restarts) replay.
                    if (!pending_s) begin
`ifdef EVENT_PLAYER_LOOP_EN
                        if (loop) begin
                            rd_ptr_q   <= '0;
                            time_now_q <= '0;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
`else
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    if (clear) begin
                        state_q     <= S_IDLE;
                        evt_count_q <= '0;
                        done_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ld.ld_ready  = ld_ready_s;
    assign input_data   = input_data_q;
    assign new_input    = new_input_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign time_now     = time_now_q;
    assign evt_count    = evt_count_q;
    assign late_cnt     = late_cnt_q;
endmodule

// File: tb/tb_event_stimulus_player.sv
// Directed bench for event_stimulus_player: vector table of replay scenarios plus hand sequences.
// Define EVENT_PLAYER_LOOP_EN to also exercise the loop port.
module tb_event_stimulus_player;
    localparam int NI = 4;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int TW = 16;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst, en, start, clear;
`ifdef EVENT_PLAYER_LOOP_EN
    logic loop;
`endif
    logic [NI*DW-1:0] input_data;
    logic [NI-1:0]    new_input;
    logic             busy, done;
    logic [TW-1:0]    time_now;
    logic [CW-1:0]    evt_count;
    logic [7:0]       late_cnt;

    event_stimulus_player_if #(.NUM_INPUTS(NI), .DATA_W(DW), .TS_W(TW)) ldif ();

    event_stimulus_player #(.NUM_INPUTS(NI), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef EVENT_PLAYER_LOOP_EN
        .loop       (loop),
`endif
        .start      (start),
        .clear      (clear),
        .ld         (ldif),
        .input_data (input_data),
        .new_input  (new_input),
        .busy       (busy),
        .done       (done),
        .time_now   (time_now),
        .evt_count  (evt_count),
        .late_cnt   (late_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0]    ts;
        logic [NI-1:0]    mask;
        logic [NI*DW-1:0] data;
        int               exp_cyc;
        int               exp_tn;
        logic [NI*DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        int first;
        int n;
        int pause_at;
        int pause_len;
        int exp_late;
    } scen_t;

    vec_t  vecs [9];
    scen_t scens [4];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_ev(input logic [TW-1:0] ts, input logic [NI-1:0] m,
                           input logic [NI*DW-1:0] d, output logic acc);
        ldif.ld_valid = 1'b1;
        ldif.ld_ts    = ts;
        ldif.ld_mask  = m;
        ldif.ld_data  = d;
        #1 acc = ldif.ld_ready;
        @(negedge clk);
        ldif.ld_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_scen(input int s);
        logic acc;
        int cyc, got;
        bit fin;
        int cc [8];
        int ct [8];
        logic [NI-1:0]    cm [8];
        logic [NI*DW-1:0] cd [8];
        for (int i = 0; i < scens[s].n; i++) begin
            load_ev(vecs[scens[s].first+i].ts, vecs[scens[s].first+i].mask,
                    vecs[scens[s].first+i].data, acc);
            check($sformatf("s%0d_load_ready_%0d", s, i), acc, 1);
        end
        check($sformatf("s%0d_evt_count", s), evt_count, scens[s].n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("s%0d_busy_run", s), busy, 1);
        cyc = 0; got = 0; fin = 1'b0;
        while (!fin && cyc < 600) begin
            if (cyc == scens[s].pause_at) en = 1'b0;
            if (cyc == scens[s].pause_at + scens[s].pause_len) en = 1'b1;
            if (new_input != '0) begin
                if (got < 8) begin
                    cc[got] = cyc; ct[got] = int'(time_now);
                    cm[got] = new_input; cd[got] = input_data;
                end
                got++;
            end
            if (done) fin = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        en = 1'b1;
        check($sformatf("s%0d_reached_done", s), fin, 1);
        check($sformatf("s%0d_pulse_count", s), got, scens[s].n);
        for (int i = 0; i < scens[s].n && i < got && i < 8; i++) begin
            check($sformatf("s%0d_ev%0d_cycle", s, i), cc[i], vecs[scens[s].first+i].exp_cyc);
            check($sformatf("s%0d_ev%0d_time_now", s, i), ct[i], vecs[scens[s].first+i].exp_tn);
            check($sformatf("s%0d_ev%0d_mask", s, i), cm[i], vecs[scens[s].first+i].mask);
            check($sformatf("s%0d_ev%0d_data", s, i), cd[i], vecs[scens[s].first+i].exp_data);
        end
        check($sformatf("s%0d_late_cnt", s), late_cnt, scens[s].exp_late);
        check($sformatf("s%0d_busy_done", s), busy, 0);
        do_clear();
        check($sformatf("s%0d_idle_after_clear", s), {done, evt_count}, 0);
    endtask

    initial begin
        logic acc;
        int cyc, got;
        rst = 1'b0; en = 1'b1; start = 1'b0; clear = 1'b0;
`ifdef EVENT_PLAYER_LOOP_EN
        loop = 1'b0;
`endif
        ldif.ld_valid = 1'b0; ldif.ld_ts = '0; ldif.ld_mask = '0; ldif.ld_data = '0;

        vecs[0] = '{16'd50,  4'b0001, 64'hAAAA_BBBB_CCCC_0001, 51, 51, 64'h0000_0000_0000_0001};
        vecs[1] = '{16'd100, 4'b0001, 64'h0000_0000_0000_0002, 101, 101, 64'h0000_0000_0000_0002};
        vecs[2] = '{16'd150, 4'b0001, 64'h0000_0000_0000_0003, 151, 151, 64'h0000_0000_0000_0003};
        vecs[3] = '{16'd10,  4'b0101, 64'h5678_0009_1234_FFF9, 11, 11, 64'h0000_0009_0000_FFF9};
        vecs[4] = '{16'd20,  4'b0001, 64'h0000_0000_0000_0001, 21, 21, 64'h0000_0000_0000_0001};
        vecs[5] = '{16'd20,  4'b0010, 64'h0000_0000_0002_0000, 22, 22, 64'h0000_0000_0002_0000};
        vecs[6] = '{16'd5,   4'b1000, 64'h0003_0000_0000_0000, 23, 23, 64'h0003_0000_0000_0000};
        vecs[7] = '{16'd5,   4'b0001, 64'h0000_0000_0000_0007, 6, 6, 64'h0000_0000_0000_0007};
        vecs[8] = '{16'd30,  4'b0001, 64'h0000_0000_0000_0008, 41, 31, 64'h0000_0000_0000_0008};
        scens[0] = '{0, 3, -1, 0, 0};
        scens[1] = '{3, 1, -1, 0, 0};
        scens[2] = '{4, 3, -1, 0, 2};
        scens[3] = '{7, 2, 12, 10, 0};

        // Reset held for three edges, then start on an empty table.
        repeat (3) @(negedge clk);
        check("reset_outputs", {new_input, input_data, time_now, late_cnt, busy, done, evt_count}, 0);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_start_done", done, 1);
        check("empty_start_no_pulse", {new_input, busy}, 0);
        do_clear();
        check("empty_clear_idle", done, 0);

        for (int s = 0; s < 4; s++) run_scen(s);

        // Full table: the fifth offer must be refused.
        for (int i = 0; i < 5; i++) begin
            load_ev(TW'(i + 1), 4'b0001, 64'(i), acc);
            check($sformatf("full_ready_%0d", i), acc, (i < 4) ? 1 : 0);
        end
        check("full_evt_count", evt_count, 4);
        do_clear();

        // start beats a simultaneous load, then reset aborts replay mid-run.
        load_ev(16'd100, 4'b0001, 64'h1, acc);
        ldif.ld_valid = 1'b1;
        start = 1'b1;
        #1 check("start_blocks_load", ldif.ld_ready, 0);
        @(negedge clk);
        start = 1'b0; ldif.ld_valid = 1'b0;
        check("start_load_evt_count", evt_count, 1);
        cyc = 0;
        while (time_now != 16'd30 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("midrun_reached_t30", time_now, 30);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrun_reset", {busy, done, evt_count, new_input, time_now}, 0);

`ifdef EVENT_PLAYER_LOOP_EN
        begin
            int exp_c [4] = '{3, 5, 9, 11};
            int exp_t [4] = '{3, 5, 3, 5};
            load_ev(16'd2, 4'b0001, 64'h11, acc);
            load_ev(16'd4, 4'b0001, 64'h22, acc);
            loop = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0; got = 0;
            while (!done && cyc < 40) begin
                if (new_input != '0) begin
                    if (got < 4) begin
                        check($sformatf("loop_cycle_%0d", got), cyc, exp_c[got]);
                        check($sformatf("loop_time_now_%0d", got), time_now, exp_t[got]);
                    end
                    got++;
                end
                if (cyc == 11) loop = 1'b0;
                @(negedge clk);
                cyc++;
            end
            check("loop_pulse_count", got, 4);
            check("loop_done", done, 1);
            do_clear();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
